// File: rtl/as2650_extbus.sv
// External-bus sequencer between the AS2650 core and the pad ring: registered
// address/data, programmable and external wait states, optional muxed A/D bus.
module as2650_extbus #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8,
  parameter int WAIT_W = 4,
  parameter int TO_W   = 6,
  parameter int MUXED  = 0
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              core_opreq,
  input  logic              core_rw,
  input  logic              core_m_io,
  input  logic [ADDR_W-1:0] core_adr,
  input  logic [DATA_W-1:0] core_dout,
  output logic [DATA_W-1:0] core_din,
  output logic              core_operack,
  input  logic [WAIT_W-1:0] cfg_wait,
  output logic              bus_err,
  output logic              busy,
  output logic [ADDR_W-1:0] io_adr,
  output logic              io_m_io,
  input  logic [DATA_W-1:0] io_dbus_in,
  output logic [DATA_W-1:0] io_dbus_out,
  output logic [DATA_W-1:0] io_oeb,
  output logic              io_ale,
  output logic              io_rd_n,
  output logic              io_wr_n,
  input  logic              io_wait,
  output logic [2:0]        dbg_state_o
);

  // Handshake: core_opreq is held high by the core until core_operack; a
  // request is accepted only in IDLE, core_operack pulses for one cycle in
  // ACK, and the core must drop or renew core_opreq during that ACK cycle.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_ACK    = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic                rw_q, rw_d;
  logic                mio_q, mio_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic                err_q, err_d;

  // Pad-facing flops, decoded from the next state so that every pad pin is a
  // register output aligned with the state it belongs to.
  logic                rd_n_q, rd_n_d;
  logic                wr_n_q, wr_n_d;
  logic                ale_q, ale_d;
  logic [DATA_W-1:0]   oeb_q, oeb_d;
  logic [DATA_W-1:0]   dbus_q, dbus_d;
  logic                ack_q, ack_d;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    to_d    = to_q;
    rw_d    = rw_q;
    mio_d   = mio_q;
    adr_d   = adr_q;
    dout_d  = dout_q;
    din_d   = din_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (core_opreq) begin
          rw_d    = core_rw;
          mio_d   = core_m_io;
          adr_d   = core_adr;
          dout_d  = core_dout;
          wcnt_d  = cfg_wait;
          to_d    = '0;
          err_d   = 1'b0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: state_d = S_STROBE;
      S_STROBE: begin
        if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - WAIT_W'(1);
        end else if (!io_wait) begin
          if (!rw_q) din_d = io_dbus_in;
          state_d = S_HOLD;
        end else if (to_q == '1) begin
          // External device never released wait: abandon the cycle.
          err_d = 1'b1;
          if (!rw_q) din_d = '1;
          state_d = S_HOLD;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_HOLD:  state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_n_d = !(state_d == S_STROBE && !rw_d);
    wr_n_d = !(state_d == S_STROBE && rw_d);
    ale_d  = (MUXED != 0) && (state_d == S_ADDR);
    ack_d  = (state_d == S_ACK);
    oeb_d  = '1;
    dbus_d = dbus_q;
    case (state_d)
      S_ADDR: begin
        if (MUXED != 0) begin
          oeb_d  = '0;
          dbus_d = adr_d[DATA_W-1:0];
        end
      end
      // Write data stays on the bus through HOLD for hold time after wr_n rises.
      S_STROBE, S_HOLD: begin
        if (rw_d) begin
          oeb_d  = '0;
          dbus_d = dout_d;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      to_q    <= '0;
      rw_q    <= 1'b0;
      mio_q   <= 1'b0;
      adr_q   <= '0;
      dout_q  <= '0;
      din_q   <= '0;
      err_q   <= 1'b0;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      ale_q   <= 1'b0;
      oeb_q   <= '1;
      dbus_q  <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      to_q    <= to_d;
      rw_q    <= rw_d;
      mio_q   <= mio_d;
      adr_q   <= adr_d;
      dout_q  <= dout_d;
      din_q   <= din_d;
      err_q   <= err_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      ale_q   <= ale_d;
      oeb_q   <= oeb_d;
      dbus_q  <= dbus_d;
      ack_q   <= ack_d;
    end
  end

  assign core_din     = din_q;
  assign core_operack = ack_q;
  assign bus_err      = err_q;
  assign busy         = (state_q != S_IDLE);
  assign io_adr       = adr_q;
  assign io_m_io      = mio_q;
  assign io_dbus_out  = dbus_q;
  assign io_oeb       = oeb_q;
  assign io_ale       = ale_q;
  assign io_rd_n      = rd_n_q;
  assign io_wr_n      = wr_n_q;
  assign dbg_state_o  = state_q;

endmodule
